// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: MEM stage has priority, DMA gets a forced slot after STARVE_MAX denials.
// Latency: pipeline and DMA access are combinational (0 cycles); DMA read data is registered, 1 cycle after dma_gnt.
// Backpressure: pipe_stall holds the MEM stage only in a forced DMA cycle; DMA holds its request until dma_gnt.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_req,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              pipe_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    PIPE_PRI  = 1'b0,
    DMA_FORCE = 1'b1
  } state_t;

  // Counter limits; STARVE_MAX is 1..15 so both fit the 4-bit counter.
  localparam logic [3:0] CNT_MAX  = 4'(STARVE_MAX);
  localparam logic [3:0] CNT_LAST = 4'(STARVE_MAX - 1);

  state_t     state;
  logic [3:0] deny_cnt;
  logic       own_dma;
  logic       gnt_raw;
  logic       deny;

  // Port ownership: DMA wins when the pipeline is idle, or unconditionally in a forced cycle.
  always_comb begin
    own_dma = dma_req && ((state == DMA_FORCE) || !pipe_req);
    gnt_raw = own_dma;
    deny    = dma_req && !gnt_raw;
  end

  // Memory-side mux and handshakes; reset forces every strobe and the address/data bus low.
  always_comb begin
    pipe_rdata = mem_rdata;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    dma_gnt    = 1'b0;
    pipe_stall = 1'b0;
    if (!rst) begin
      if (own_dma) begin
        mem_we    = dma_we && dma_req;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
      end else begin
        mem_we    = pipe_we && pipe_req;
        mem_addr  = pipe_addr;
        mem_wdata = pipe_wdata;
      end
      dma_gnt    = gnt_raw;
      pipe_stall = pipe_req && own_dma;
    end
  end

  // Starvation guard: count consecutive DMA denials and schedule one forced DMA cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= PIPE_PRI;
      deny_cnt <= 4'd0;
    end else begin
      case (state)
        PIPE_PRI: begin
          if (deny && (deny_cnt == CNT_LAST)) begin
            state    <= DMA_FORCE;
            deny_cnt <= 4'd0;
          end else if (deny) begin
            deny_cnt <= (deny_cnt == CNT_MAX) ? deny_cnt : deny_cnt + 4'd1;
          end else begin
            deny_cnt <= 4'd0;
          end
        end
        DMA_FORCE: begin
          // Either granted or withdrawn this cycle; both clear the count.
          state    <= PIPE_PRI;
          deny_cnt <= 4'd0;
        end
        default: begin
          state    <= PIPE_PRI;
          deny_cnt <= 4'd0;
        end
      endcase
    end
  end

  // DMA read return: capture memory data one edge after a granted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_rvalid <= gnt_raw && !dma_we;
      if (gnt_raw && !dma_we) begin
        dma_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of per-cycle vectors plus hand-written reset corner cases.
// Expected DMA read data is queued at grant time and popped when dma_rvalid is due.
// A small word-addressed memory stands in for DataMemory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_req, pipe_we;
  logic [31:0] pipe_addr, pipe_wdata, pipe_rdata;
  logic        pipe_stall;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_req   (pipe_req),
    .pipe_we    (pipe_we),
    .pipe_addr  (pipe_addr),
    .pipe_wdata (pipe_wdata),
    .pipe_rdata (pipe_rdata),
    .pipe_stall (pipe_stall),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // DataMemory stand-in: combinational read, write at the rising edge.
  logic [31:0] mem [256] = '{default: '0};
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[9:2]];

  typedef struct {
    logic        preq, pwe;
    logic [31:0] paddr, pwd;
    logic        dreq, dwe;
    logic [31:0] daddr, dwd;
    logic        e_gnt, e_stall, e_we;
    logic [31:0] e_addr;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] ref_mem [256];
  logic [31:0] exp_q[$];
  logic        prev_rd;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic vec_t mk(logic preq, logic pwe, logic [31:0] paddr, logic [31:0] pwd,
                              logic dreq, logic dwe, logic [31:0] daddr, logic [31:0] dwd,
                              logic g, logic s, logic w, logic [31:0] a);
    vec_t v;
    v.preq = preq; v.pwe = pwe; v.paddr = paddr; v.pwd = pwd;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
    v.e_gnt = g; v.e_stall = s; v.e_we = w; v.e_addr = a;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    pipe_req = v.preq; pipe_we = v.pwe; pipe_addr = v.paddr; pipe_wdata = v.pwd;
    dma_req  = v.dreq; dma_we  = v.dwe; dma_addr  = v.daddr; dma_wdata  = v.dwd;
  endtask

  // Check the pending read return, then one cycle of arbitration outputs.
  task automatic check_rvalid(input string tag);
    chk({tag, " rvalid"}, 32'(dma_rvalid), 32'(prev_rd));
    if (prev_rd && dma_rvalid) begin
      if (exp_q.size() == 0) chk({tag, " rdata(no expectation)"}, 32'd1, 32'd0);
      else chk({tag, " rdata"}, dma_rdata, exp_q.pop_front());
    end
  endtask

  task automatic step(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    drive(v);
    @(negedge clk);
    check_rvalid(tag);
    chk({tag, " gnt"},   32'(dma_gnt),    32'(v.e_gnt));
    chk({tag, " stall"}, 32'(pipe_stall), 32'(v.e_stall));
    chk({tag, " we"},    32'(mem_we),     32'(v.e_we));
    chk({tag, " addr"},  mem_addr,        v.e_addr);
    if (v.e_we) chk({tag, " wdata"}, mem_wdata, v.e_gnt ? v.dwd : v.pwd);
    if (v.preq && !v.pwe && !v.e_stall) chk({tag, " pipe_rdata"}, pipe_rdata, ref_mem[v.paddr[9:2]]);
    prev_rd = v.e_gnt && !v.dwe;
    if (prev_rd) exp_q.push_back(ref_mem[v.daddr[9:2]]);
    if (v.e_we) ref_mem[v.e_addr[9:2]] = v.e_gnt ? v.dwd : v.pwd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    foreach (ref_mem[i]) ref_mem[i] = '0;
    prev_rd = 1'b0;

    // Vector table (STARVE_MAX = 4).
    vecs.push_back(mk(1,1,'h10,'hA5,       1,1,'h40,'hDEADBEEF, 0,0,1,'h10)); // pipe first after reset
    vecs.push_back(mk(0,0,'h10,0,          1,1,'h40,'hDEADBEEF, 1,0,1,'h40)); // idle pipe: DMA write
    vecs.push_back(mk(0,0,'h10,0,          1,0,'h40,0,          1,0,0,'h40)); // DMA read
    vecs.push_back(mk(0,0,'h10,0,          1,1,'h48,'hCAFEF00D, 1,0,1,'h48));
    vecs.push_back(mk(0,1,'h10,'h55,       0,0,0,0,             0,0,0,'h10)); // nominal owner, no write
    vecs.push_back(mk(1,0,'h10,0,          0,0,0,0,             0,0,0,'h10));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1,0,'h10,0,        1,0,'h40,0,          0,0,0,'h10)); // contention 0-3
    vecs.push_back(mk(1,0,'h10,0,          1,0,'h40,0,          1,1,0,'h40)); // forced cycle 4
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1,1,'h14,'h77,     1,1,'h44,'h12345678, 0,0,1,'h14)); // cycles 5-8
    vecs.push_back(mk(1,1,'h14,'h77,       1,1,'h44,'h12345678, 1,1,1,'h44)); // forced cycle 9
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1,0,'h80,0,        1,1,'h80,'h11,       0,0,0,'h80)); // hazard lead-in
    vecs.push_back(mk(1,0,'h80,0,          1,1,'h80,'h11,       1,1,1,'h80)); // forced write, load stalls
    vecs.push_back(mk(1,0,'h80,0,          0,0,0,0,             0,0,0,'h80)); // re-issued load sees 0x11
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1,0,'h44,0,        1,0,'h48,0,          0,0,0,'h44)); // withdraw lead-in
    vecs.push_back(mk(1,0,'h44,0,          0,0,'h48,0,          0,0,0,'h44)); // dma_req drops in force
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1,0,'h14,0,        1,0,'h48,0,          0,0,0,'h14)); // count restarted at 0
    vecs.push_back(mk(1,0,'h14,0,          1,0,'h48,0,          1,1,0,'h48));
    vecs.push_back(mk(0,0,'h14,0,          1,0,'h40,0,          1,0,0,'h40)); // back-to-back reads
    vecs.push_back(mk(0,0,'h14,0,          1,0,'h48,0,          1,0,0,'h48));
    vecs.push_back(mk(0,0,'h14,0,          0,0,0,0,             0,0,0,'h14));

    // Reset with both requesters active.
    rst = 1'b1;
    drive(mk(1,1,'h10,'hA5, 1,1,'h40,'hDEADBEEF, 0,0,0,0));
    @(negedge clk);
    chk("reset we",     32'(mem_we),     32'd0);
    chk("reset gnt",    32'(dma_gnt),    32'd0);
    chk("reset stall",  32'(pipe_stall), 32'd0);
    chk("reset rvalid", 32'(dma_rvalid), 32'd0);
    chk("reset addr",   mem_addr,        32'd0);
    chk("reset wdata",  mem_wdata,       32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) step(i, vecs[i]);

    // Reset in the cycle after a granted DMA read.
    step(100, mk(0,0,'h10,0, 1,0,'h40,0, 1,0,0,'h40));
    drive(mk(0,0,'h10,0, 0,0,0,0, 0,0,0,0));
    #1;
    check_rvalid("pre-reset");
    rst = 1'b1;
    #1;
    chk("midread rvalid", 32'(dma_rvalid), 32'd0);
    chk("midread rdata",  dma_rdata,       32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    prev_rd = 1'b0;
    exp_q.delete();

    // Reset during a forced DMA write: nothing written, PIPE_PRI afterwards.
    for (int i = 0; i < 4; i++) step(110 + i, mk(1,0,'h10,0, 1,1,'h90,'h99, 0,0,0,'h10));
    #2;
    chk("force gnt",   32'(dma_gnt),    32'd1);
    chk("force stall", 32'(pipe_stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("force-rst gnt",   32'(dma_gnt),    32'd0);
    chk("force-rst we",    32'(mem_we),     32'd0);
    chk("force-rst stall", 32'(pipe_stall), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("force-rst no write", mem[8'h24], 32'd0);
    step(120, mk(1,0,'h10,0, 1,1,'h90,'h99, 0,0,0,'h10));
    step(121, mk(0,0,'h10,0, 1,1,'h90,'h99, 1,0,1,'h90));
    step(122, mk(1,0,'h90,0, 0,0,0,0,       0,0,0,'h90));

    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
